mem_access_unit: RTL and testbench

- MEM-stage block directly downstream of the ALU.
- Consumes the ALU result as an effective address, together with the 8-bit op code and the rt store data.
- Drives a split-transaction data-SRAM interface (req/addr_ok/data_ok), generates byte strobes, checks alignment, and sign/zero-extends load data.
- Stalls the pipeline until the access completes.

---
 rtl/mem_access_unit_pkg.sv | 68 ++++++
 rtl/mem_load_ext.sv | 28 ++
 rtl/mem_access_unit.sv | 177 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// Shared constants for the MEM-stage access unit: op codes, FSM encoding,
// access sizes and the byte-strobe / lane-replication helpers.
package mem_access_unit_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] MAU_IDLE  = 2'd0;
  localparam logic [1:0] MAU_REQ   = 2'd1;
  localparam logic [1:0] MAU_WAIT  = 2'd2;
  localparam logic [1:0] MAU_DRAIN = 2'd3;

  typedef enum logic [1:0] {SZ_NONE, SZ_BYTE, SZ_HALF, SZ_WORD} mau_size_e;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_BYTE = 4'b0001;
  localparam logic [3:0] STRB_HALF = 4'b0011;
  localparam logic [3:0] STRB_WORD = 4'b1111;

  function automatic logic is_load(input logic [7:0] op);
    return op inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP};
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return op inside {EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};
  endfunction

  function automatic mau_size_e op_size(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return SZ_BYTE;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return SZ_HALF;
      EXE_LW_OP, EXE_SW_OP:             return SZ_WORD;
      default:                          return SZ_NONE;
    endcase
  endfunction

  function automatic logic is_aligned(input mau_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return a == 2'b00;
      SZ_HALF: return ~a[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input mau_size_e sz, input logic [1:0] a);
    case (sz)
      SZ_WORD: return STRB_WORD;
      SZ_HALF: return a[1] ? (STRB_HALF << 2) : STRB_HALF;
      SZ_BYTE: return STRB_BYTE << a;
      default: return STRB_NONE;
    endcase
  endfunction

  function automatic logic [31:0] store_data(input mau_size_e sz, input logic [31:0] w);
    case (sz)
      SZ_HALF: return {2{w[15:0]}};
      SZ_BYTE: return {4{w[7:0]}};
      default: return w;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Combinational load-lane selector: picks the byte/halfword addressed by
// addr_lo_i out of the raw SRAM word and sign- or zero-extends it.
module mem_load_ext
  import mem_access_unit_pkg::*;
(
  input  logic [7:0]  op_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      EXE_LB_OP:  result_o = {{24{byte_sel[7]}}, byte_sel};
      EXE_LBU_OP: result_o = {24'd0, byte_sel};
      EXE_LH_OP:  result_o = {{16{half_sel[15]}}, half_sel};
      EXE_LHU_OP: result_o = {16'd0, half_sel};
      EXE_LW_OP:  result_o = rdata_i;
      default:    result_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data-SRAM access unit (split req/addr_ok/data_ok handshake).
// Define MAU_TIMEOUT_EN to add the addr_ok/data_ok watchdog driving bus_err.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 8
)
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        en,
  input  logic [7:0]  op,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] result,
  output logic        result_valid,
  output logic        mem_stall,
  output logic        adel,
  output logic        ades,
  output logic [31:0] bad_addr,
  output logic        bus_err
);

  logic [1:0]  state_q, state_d;
  logic [7:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] result_q, result_d;
  logic        result_valid_q, result_valid_d;
  logic        in_ld, in_st, in_mem, in_aligned, start, misalign, complete;
  mau_size_e   in_size, q_size;
  logic [31:0] ext_data;

  always_comb begin
    in_ld      = is_load(op);
    in_st      = is_store(op);
    in_mem     = in_ld | in_st;
    in_size    = op_size(op);
    in_aligned = is_aligned(in_size, addr[1:0]);
    start      = en & in_mem & in_aligned & ~flush;
    misalign   = en & in_mem & ~in_aligned & ~flush;
  end

  assign adel     = misalign & in_ld;
  assign ades     = misalign & in_st;
  assign bad_addr = misalign ? addr : 32'd0;

  mem_load_ext u_load_ext (
    .op_i      (op_q),
    .addr_lo_i (addr_q[1:0]),
    .rdata_i   (data_rdata),
    .result_o  (ext_data)
  );

`ifdef MAU_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_err_q, bus_err_d;
`else
  logic [31:0] unused_cfg;
  assign unused_cfg = 32'(TIMEOUT_CYCLES + CNT_W);
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    complete = 1'b0;
    case (state_q)
      MAU_IDLE: if (start) begin
        state_d = MAU_REQ;
        op_d    = op;
        addr_d  = addr;
        wdata_d = wdata;
      end
      MAU_REQ: begin
        // addr_ok+data_ok together closes the whole transaction in one cycle
        if (data_addr_ok) begin
          if (data_data_ok) begin
            state_d  = MAU_IDLE;
            complete = ~flush;
          end else begin
            state_d = flush ? MAU_DRAIN : MAU_WAIT;
          end
        end else if (flush) begin
          state_d = MAU_IDLE;
        end
      end
      MAU_WAIT: begin
        if (data_data_ok) begin
          state_d  = MAU_IDLE;
          complete = ~flush;
        end else if (flush) begin
          state_d = MAU_DRAIN;
        end
      end
      MAU_DRAIN: if (data_data_ok) state_d = MAU_IDLE;
      default: state_d = MAU_IDLE;
    endcase
`ifdef MAU_TIMEOUT_EN
    bus_err_d = 1'b0;
    if (state_q != MAU_IDLE && state_d == state_q &&
        cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
      state_d   = MAU_IDLE;
      bus_err_d = 1'b1;
    end
    cnt_d = (state_q == MAU_IDLE || state_d != state_q) ? '0 : cnt_q + CNT_W'(1);
`endif
    result_valid_d = complete;
    result_d       = result_q;
    if (complete) result_d = is_store(op_q) ? 32'd0 : ext_data;
  end

  always_comb begin
    case (state_q)
      MAU_IDLE:  mem_stall = start;
      MAU_REQ:   mem_stall = ~(data_addr_ok & data_data_ok);
      MAU_WAIT:  mem_stall = ~data_data_ok;
      MAU_DRAIN: mem_stall = en & in_mem;
      default:   mem_stall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= MAU_IDLE;
      op_q           <= 8'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      result_q       <= 32'd0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      op_q           <= op_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

`ifdef MAU_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  // Request fields come only from latched state, so they cannot move during REQ
  assign q_size       = op_size(op_q);
  assign data_req     = (state_q == MAU_REQ);
  assign data_wr      = data_req & is_store(op_q);
  assign data_wstrb   = data_wr ? store_strb(q_size, addr_q[1:0]) : STRB_NONE;
  assign data_addr    = {addr_q[31:2], 2'b00};
  assign data_wdata   = store_data(q_size, wdata_q);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed cases plus random traffic
// checked against a byte-level reference model.
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk, rst, flush, en;
  logic [7:0]  op;
  logic [31:0] addr, wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic        data_req, data_wr, result_valid, mem_stall, adel, ades, bus_err;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, result, bad_addr;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  req_t        req_q[$];
  logic [31:0] res_q[$];
  req_t        mon_e;

  mem_access_unit #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .flush(flush), .en(en), .op(op), .addr(addr), .wdata(wdata),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .result(result), .result_valid(result_valid),
    .mem_stall(mem_stall), .adel(adel), .ades(ades), .bad_addr(bad_addr), .bus_err(bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [7:0] o);
    if (o == EXE_LB_OP || o == EXE_LBU_OP || o == EXE_SB_OP) return 1;
    if (o == EXE_LH_OP || o == EXE_LHU_OP || o == EXE_SH_OP) return 2;
    if (o == EXE_LW_OP || o == EXE_SW_OP) return 4;
    return 0;
  endfunction

  function automatic bit ref_is_store(input logic [7:0] o);
    return o == EXE_SB_OP || o == EXE_SH_OP || o == EXE_SW_OP;
  endfunction

  function automatic req_t ref_req(input logic [7:0] o, input logic [31:0] a, input logic [31:0] w);
    req_t r;
    int n, off;
    n = nbytes(o);
    off = int'(a[1:0]);
    r.addr = a & ~32'h3;
    r.wr = ref_is_store(o);
    r.strb = 4'b0;
    r.wdata = 32'b0;
    if (r.wr) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + n) r.strb[i] = 1'b1;
        r.wdata[8*i +: 8] = w[8*(i % n) +: 8];
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] ref_result(input logic [7:0] o, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    bit sgn;
    if (ref_is_store(o)) return 32'd0;
    sgn = (o == EXE_LB_OP || o == EXE_LH_OP);
    v = rd >> (8 * int'(a[1:0]));
    if (nbytes(o) == 1) begin
      v = v & 32'hFF;
      if (sgn && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nbytes(o) == 2) begin
      v = v & 32'hFFFF;
      if (sgn && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // Monitor: request fields must match the outstanding expectation on every
  // REQ cycle; results are popped whenever result_valid pulses.
  always @(negedge clk) begin
    if (rst) begin
      if (data_req) begin
        if (req_q.size() == 0) begin
          chk("req_outstanding", {31'd0, data_req}, 32'd0);
        end else begin
          mon_e = req_q[0];
          chk("data_addr", data_addr, mon_e.addr);
          chk("data_wr", {31'd0, data_wr}, {31'd0, mon_e.wr});
          chk("data_wstrb", {28'd0, data_wstrb}, {28'd0, mon_e.strb});
          if (mon_e.wr) chk("data_wdata", data_wdata, mon_e.wdata);
          if (data_addr_ok) void'(req_q.pop_front());
        end
      end
      if (result_valid) begin
        if (res_q.size() == 0) chk("result_valid_unexpected", {31'd0, result_valid}, 32'd0);
        else chk("result", result, res_q.pop_front());
      end
`ifndef MAU_TIMEOUT_EN
      chk("bus_err_tied", {31'd0, bus_err}, 32'd0);
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op as the EX stage and play the SRAM: addr_ok after al REQ
  // cycles, data_ok dl cycles after addr_ok (0 = same cycle).
  task automatic do_op(input logic [7:0] o, input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] rd, input int al, input int dl, input bit timing);
    int n;
    bit mis;
    n = nbytes(o);
    cyc();
    en = 1'b1; op = o; addr = a; wdata = wd;
    #1;
    if (n == 0) begin
      chk("nonmem_stall", {31'd0, mem_stall}, 32'd0);
      cyc(); en = 1'b0; #1;
      chk("nonmem_no_req", {31'd0, data_req}, 32'd0);
      return;
    end
    mis = (int'(a[1:0]) % n) != 0;
    if (mis) begin
      chk("adel", {31'd0, adel}, {31'd0, !ref_is_store(o)});
      chk("ades", {31'd0, ades}, {31'd0, ref_is_store(o)});
      chk("bad_addr", bad_addr, a);
      chk("mis_stall", {31'd0, mem_stall}, 32'd0);
      cyc(); en = 1'b0; #1;
      chk("mis_no_req", {31'd0, data_req}, 32'd0);
      return;
    end
    req_q.push_back(ref_req(o, a, wd));
    res_q.push_back(ref_result(o, a, rd));
    chk("stall_t0", {31'd0, mem_stall}, 32'd1);
    cyc();
    repeat (al) cyc();
    data_addr_ok = 1'b1;
    if (dl == 0) begin
      data_data_ok = 1'b1;
      data_rdata = rd;
    end
    #1;
    if (timing) chk("stall_t1", {31'd0, mem_stall}, {31'd0, dl != 0});
    cyc();
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = $urandom;
    if (dl > 0) begin
      repeat (dl - 1) cyc();
      data_data_ok = 1'b1;
      data_rdata = rd;
      #1;
      if (timing) begin
        chk("stall_t2", {31'd0, mem_stall}, 32'd0);
        chk("no_rv_t2", {31'd0, result_valid}, 32'd0);
      end
      cyc();
      data_data_ok = 1'b0;
      data_rdata = $urandom;
    end
    en = 1'b0;
    if (timing) chk("rv_t3", {31'd0, result_valid}, 32'd1);
  endtask

  logic [7:0]  ops [10];
  logic [7:0]  r_op;
  logic [31:0] r_addr;
  int          r_n;

  initial begin
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP,
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, 8'h21, 8'h00};
    rst = 1'b0; flush = 1'b0; en = 1'b0; op = 8'd0; addr = 32'd0; wdata = 32'd0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
    repeat (3) cyc();
    chk("rst_data_req", {31'd0, data_req}, 32'd0);
    chk("rst_mem_stall", {31'd0, mem_stall}, 32'd0);
    chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_data_addr", data_addr, 32'd0);
    chk("rst_data_wstrb", {28'd0, data_wstrb}, 32'd0);
    chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
    rst = 1'b1;
    cyc();

    do_op(EXE_LW_OP, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b1);
    do_op(EXE_LB_OP, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 1, 1'b0);
    do_op(EXE_LBU_OP, 32'h0000_1003, 32'h0, 32'h80FF_FFFF, 0, 1, 1'b0);
    do_op(EXE_SH_OP, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 1, 2, 1'b0);
    do_op(EXE_LW_OP, 32'h0000_1002, 32'h0, 32'h0, 0, 1, 1'b0);
    do_op(EXE_SH_OP, 32'h0000_1001, 32'h0, 32'h0, 0, 1, 1'b0);
    do_op(EXE_LHU_OP, 32'h0000_1006, 32'h0, 32'h8001_7FFE, 0, 0, 1'b1);

    // Flush while waiting for data: one data_ok is swallowed, no result
    cyc(); en = 1'b1; op = EXE_LW_OP; addr = 32'h0000_3008;
    req_q.push_back(ref_req(EXE_LW_OP, 32'h0000_3008, 32'h0));
    cyc(); data_addr_ok = 1'b1;
    cyc(); data_addr_ok = 1'b0; flush = 1'b1; en = 1'b0;
    cyc(); flush = 1'b0; #1;
    chk("drain_stall_idle", {31'd0, mem_stall}, 32'd0);
    cyc(); en = 1'b1; op = EXE_LW_OP; addr = 32'h0000_300C; #1;
    chk("drain_stall_memop", {31'd0, mem_stall}, 32'd1);
    cyc(); en = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_AAAA;
    cyc(); data_data_ok = 1'b0; #1;
    chk("drain_no_rv", {31'd0, result_valid}, 32'd0);
    chk("drain_idle_req", {31'd0, data_req}, 32'd0);
    do_op(EXE_LW_OP, 32'h0000_3010, 32'h0, 32'h0BAD_F00D, 0, 1, 1'b1);

    // Flush in REQ without addr_ok: request withdrawn next cycle
    cyc(); en = 1'b1; op = EXE_LH_OP; addr = 32'h0000_4002;
    req_q.push_back(ref_req(EXE_LH_OP, 32'h0000_4002, 32'h0));
    cyc(); flush = 1'b1; en = 1'b0;
    cyc(); flush = 1'b0; #1;
    chk("flush_req_drop", {31'd0, data_req}, 32'd0);
    chk("flush_req_stall", {31'd0, mem_stall}, 32'd0);
    void'(req_q.pop_front());

    // Flush in REQ together with addr_ok: goes to DRAIN
    cyc(); en = 1'b1; op = EXE_SW_OP; addr = 32'h0000_4010; wdata = 32'hCAFE_0001;
    req_q.push_back(ref_req(EXE_SW_OP, 32'h0000_4010, 32'hCAFE_0001));
    cyc(); data_addr_ok = 1'b1; flush = 1'b1; en = 1'b0;
    cyc(); data_addr_ok = 1'b0; flush = 1'b0; #1;
    chk("flush_ack_req", {31'd0, data_req}, 32'd0);
    cyc(); data_data_ok = 1'b1;
    cyc(); data_data_ok = 1'b0; #1;
    chk("flush_ack_no_rv", {31'd0, result_valid}, 32'd0);
    do_op(EXE_SB_OP, 32'h0000_4013, 32'h0000_00A5, 32'h0, 0, 1, 1'b0);

`ifdef MAU_TIMEOUT_EN
    cyc(); en = 1'b1; op = EXE_LW_OP; addr = 32'h0000_5000;
    req_q.push_back(ref_req(EXE_LW_OP, 32'h0000_5000, 32'h0));
    repeat (4) begin
      cyc(); #1;
      chk("to_req_held", {31'd0, data_req}, 32'd1);
      chk("to_no_err", {31'd0, bus_err}, 32'd0);
    end
    cyc(); en = 1'b0; #1;
    chk("to_bus_err", {31'd0, bus_err}, 32'd1);
    chk("to_req_drop", {31'd0, data_req}, 32'd0);
    void'(req_q.pop_front());
    cyc(); #1;
    chk("to_bus_err_pulse", {31'd0, bus_err}, 32'd0);
`endif

    for (int i = 0; i < 200; i++) begin
      r_op = ops[$urandom_range(0, 9)];
      r_addr = $urandom;
      r_n = nbytes(r_op);
      if (r_n != 0 && $urandom_range(0, 3) != 0) r_addr = r_addr & ~32'(r_n - 1);
      do_op(r_op, r_addr, $urandom, $urandom, $urandom_range(0, 2), $urandom_range(0, 3), 1'b0);
    end

    repeat (4) cyc();
    chk("req_q_empty", req_q.size(), 32'd0);
    chk("res_q_empty", res_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
